mul_shiftadd32u: RTL and testbench



---
 rtl/mul_shiftadd32u.sv | 94 +++++++++
 tb/tb_mul_shiftadd32u.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_shiftadd32u.sv
`default_nettype none
// ============================================================================
// Module   : mul_shiftadd32u
// Brief    : Sequential unsigned 32x32->64 MSB-first shift-add multiplier
//            with quick-start normalization and zero-operand bypass.
// Revision : 1.0 - initial release
// ============================================================================
module mul_shiftadd32u (
    input  logic        clk,
    input  logic        rstLow,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    input  logic        start_in,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        busy
);

    localparam logic [1:0] c_PREP   = 2'd0;
    localparam logic [1:0] c_LOOP   = 2'd1;
    localparam logic [1:0] c_FINISH = 2'd2;
    localparam logic [1:0] c_FREE   = 2'd3;

    logic [63:0] r_acc;
    logic [31:0] r_m;
    logic [31:0] r_mcand;
    logic [4:0]  r_count;
    logic [1:0]  r_state;

    logic        w_zero;
    logic        w_start;
    logic [4:0]  w_lz;
    logic [31:0] w_b_norm;
    logic [63:0] w_addend;

    assign w_zero  = (a_in == 32'd0) | (b_in == 32'd0);
    assign w_start = start_in & ~w_zero;

    // Leading-zero count: the highest set bit wins because it is visited last.
    always_comb begin
        w_lz = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (b_in[i]) begin
                w_lz = 5'(31 - i);
            end
        end
    end

    assign w_b_norm = b_in << w_lz;
    assign w_addend = r_m[31] ? {32'd0, r_mcand} : 64'd0;

    always_ff @(posedge clk or negedge rstLow) begin
        if (!rstLow) begin
            r_state <= c_FINISH;
            r_acc   <= 64'd0;
            r_m     <= 32'd0;
            r_mcand <= 32'd0;
            r_count <= 5'd0;
        end else begin
            case (r_state)
                c_PREP: begin
                    r_acc   <= 64'd0;
                    r_m     <= w_b_norm;
                    r_mcand <= a_in;
                    r_count <= w_lz;
                    r_state <= c_LOOP;
                end
                c_LOOP: begin
                    r_acc   <= {r_acc[62:0], 1'b0} + w_addend;
                    r_m     <= {r_m[30:0], 1'b0};
                    r_count <= r_count + 5'd1;
                    if (r_count == 5'd31) begin
                        r_state <= c_FINISH;
                    end
                end
                // Free is an unused encoding and behaves as Finish.
                c_FINISH, c_FREE: begin
                    if (w_start) begin
                        r_state <= c_PREP;
                    end else begin
                        r_state <= c_FINISH;
                    end
                end
                default: r_state <= c_FINISH;
            endcase
        end
    end

    assign busy   = (r_state == c_PREP) | (r_state == c_LOOP);
    assign hi_out = w_zero ? 32'd0 : r_acc[63:32];
    assign lo_out = w_zero ? 32'd0 : r_acc[31:0];

endmodule
`default_nettype wire

// File: tb/tb_mul_shiftadd32u.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_shiftadd32u
// Brief    : Scoreboard testbench for the shift-add multiplier.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_shiftadd32u;

    logic        clk;
    logic        rstLow;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        start_in;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        busy;

    int          n_tests;
    int          n_fail;
    logic [63:0] sb_q[$];

    mul_shiftadd32u dut (
        .clk      (clk),
        .rstLow   (rstLow),
        .a_in     (a_in),
        .b_in     (b_in),
        .start_in (start_in),
        .hi_out   (hi_out),
        .lo_out   (lo_out),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int clz(input logic [31:0] v);
        int n;
        n = 0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) break;
            n++;
        end
        return n;
    endfunction

    // Counts negedges with busy high; returns at the first negedge with busy low.
    task automatic wait_busy(input int pulse_at, output int cnt);
        cnt = 0;
        @(negedge clk);
        while (busy && cnt < 100) begin
            cnt++;
            if (pulse_at > 0 && cnt == pulse_at) start_in = 1'b1;
            if (pulse_at > 0 && cnt == pulse_at + 1) start_in = 1'b0;
            @(negedge clk);
        end
        start_in = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [31:0] a,
                          input logic [31:0] b, input int pulse_at);
        int cnt;
        int exp_cnt;
        logic [63:0] exp_p;
        @(posedge clk); #1;
        a_in = a; b_in = b; start_in = 1'b1;
        sb_q.push_back(64'(a) * 64'(b));
        exp_cnt = 33 - clz(b);
        @(posedge clk); #1;
        start_in = 1'b0;
        wait_busy(pulse_at, cnt);
        n_tests++;
        if (cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL %s busy_cycles: got %0d expected %0d", name, cnt, exp_cnt);
        end
        exp_p = sb_q.pop_front();
        n_tests++;
        if ({hi_out, lo_out} !== exp_p) begin
            n_fail++;
            $display("FAIL %s product: got %h_%h expected %h", name, hi_out, lo_out, exp_p);
        end
    endtask

    task automatic test_reset();
        a_in = 32'd5; b_in = 32'd3; start_in = 1'b0; rstLow = 1'b0;
        #12;
        n_tests++;
        if (busy !== 1'b0 || hi_out !== 32'd0 || lo_out !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b hi=%h lo=%h expected 0/0/0", busy, hi_out, lo_out);
        end
        @(negedge clk);
        rstLow = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || {hi_out, lo_out} !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%b hi=%h lo=%h expected 0/0/0", busy, hi_out, lo_out);
        end
    endtask

    task automatic test_small();
        run_op("small_7x6", 32'd7, 32'd6, 0);
    endtask

    task automatic test_max();
        run_op("max_ffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        n_tests++;
        if (hi_out !== 32'hFFFF_FFFE || lo_out !== 32'h0000_0001) begin
            n_fail++;
            $display("FAIL max_const: got %h_%h expected fffffffe_00000001", hi_out, lo_out);
        end
    endtask

    task automatic test_zero_bypass();
        logic [63:0] exp_p;
        // The accumulator still holds the previous nonzero product here.
        @(posedge clk); #1;
        a_in = 32'h1234_5678; b_in = 32'd0; start_in = 1'b1;
        sb_q.push_back(64'd0);
        #1;
        exp_p = sb_q.pop_front();
        n_tests++;
        if ({hi_out, lo_out} !== exp_p) begin
            n_fail++;
            $display("FAIL bypass_b0: got %h_%h expected %h", hi_out, lo_out, exp_p);
        end
        repeat (3) begin
            @(negedge clk);
            n_tests++;
            if (busy !== 1'b0) begin
                n_fail++;
                $display("FAIL bypass_b0_busy: got %b expected 0", busy);
            end
        end
        a_in = 32'd0; b_in = 32'd9;
        sb_q.push_back(64'd0);
        #1;
        exp_p = sb_q.pop_front();
        n_tests++;
        if ({hi_out, lo_out} !== exp_p) begin
            n_fail++;
            $display("FAIL bypass_a0: got %h_%h expected %h", hi_out, lo_out, exp_p);
        end
        repeat (2) @(negedge clk);
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bypass_a0_busy: got %b expected 0", busy);
        end
        start_in = 1'b0;
        a_in = 32'hFFFF_FFFF; b_in = 32'hFFFF_FFFF;
        #1;
        n_tests++;
        if (hi_out !== 32'hFFFF_FFFE || lo_out !== 32'h0000_0001) begin
            n_fail++;
            $display("FAIL bypass_hold: got %h_%h expected fffffffe_00000001", hi_out, lo_out);
        end
    endtask

    task automatic test_ignored_start();
        run_op("ignored_start", 32'h8000_0000, 32'd2, 1);
        n_tests++;
        if (hi_out !== 32'h0000_0001 || lo_out !== 32'd0) begin
            n_fail++;
            $display("FAIL ignored_start_const: got %h_%h expected 00000001_00000000", hi_out, lo_out);
        end
    endtask

    task automatic test_reset_mid();
        int cnt;
        @(posedge clk); #1;
        a_in = 32'hFFFF_FFFF; b_in = 32'hFFFF_FFFF; start_in = 1'b1;
        @(posedge clk); #1;
        start_in = 1'b0;
        cnt = 0;
        @(negedge clk);
        while (busy && cnt < 10) begin
            cnt++;
            if (cnt < 10) @(negedge clk);
        end
        n_tests++;
        if (cnt !== 10 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_pre: busy=%b cycles=%0d expected 1 at cycle 10", busy, cnt);
        end
        #1 rstLow = 1'b0;
        #1;
        n_tests++;
        if (busy !== 1'b0 || {hi_out, lo_out} !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_mid: busy=%b hi=%h lo=%h expected 0/0/0", busy, hi_out, lo_out);
        end
        @(negedge clk);
        rstLow = 1'b1;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || {hi_out, lo_out} !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_mid_after: busy=%b hi=%h lo=%h expected 0/0/0", busy, hi_out, lo_out);
        end
    endtask

    task automatic test_back_to_back();
        int cnt;
        logic [63:0] exp_p;
        @(posedge clk); #1;
        a_in = 32'd3; b_in = 32'd5; start_in = 1'b1;
        sb_q.push_back(64'd15);
        sb_q.push_back(64'd15);
        @(posedge clk); #1;
        cnt = 0;
        @(negedge clk);
        while (busy && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        n_tests++;
        if (cnt !== 4) begin
            n_fail++;
            $display("FAIL b2b_first_busy: got %0d expected 4", cnt);
        end
        exp_p = sb_q.pop_front();
        n_tests++;
        if ({hi_out, lo_out} !== exp_p) begin
            n_fail++;
            $display("FAIL b2b_first: got %h_%h expected %h", hi_out, lo_out, exp_p);
        end
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_rerise: got %b expected 1", busy);
        end
        start_in = 1'b0;
        cnt = 1;
        @(negedge clk);
        while (busy && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        n_tests++;
        if (cnt !== 4) begin
            n_fail++;
            $display("FAIL b2b_second_busy: got %0d expected 4", cnt);
        end
        exp_p = sb_q.pop_front();
        n_tests++;
        if ({hi_out, lo_out} !== exp_p) begin
            n_fail++;
            $display("FAIL b2b_second: got %h_%h expected %h", hi_out, lo_out, exp_p);
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        for (int k = 0; k < 6; k++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(31, 0);
            if (a == 32'd0) a = 32'd1;
            if (b == 32'd0) b = 32'd1;
            run_op("random", a, b, 0);
        end
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rstLow   = 1'b0;
        a_in     = 32'd0;
        b_in     = 32'd0;
        start_in = 1'b0;
        test_reset();
        test_small();
        test_max();
        test_zero_bypass();
        test_ignored_start();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
